tcm_pmem_axi: RTL

AXI4 slave that gives the system bus (loader, debug, DMA) access to port 1 of the 64-bit dual-port TCM RAM.
- Accepts 32-bit INCR bursts, one transaction at a time.
- Converts each beat into a byte-strobed 64-bit RAM write, or a one-cycle-latency RAM read.
- Sits directly upstream of the TCM RAM; the CPU core owns port 0.

---
 rtl/tcm_pkg.sv | 25 ++
 rtl/tcm_pmem_axi.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tcm_pkg.sv
// Shared types and constants for the TCM port-1 AXI bridge.
package tcm_pkg;

  // Bridge transaction FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_BRESP,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_RD_DATA
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // 64-bit word index width of the TCM RAM (byte address bits [15:3]).
  localparam int TCM_WORD_ADDR_W = 13;

  // Place a 32-bit beat's byte strobes onto the half of the 64-bit word picked by addr[2].
  function automatic logic [7:0] lane_enables(input logic sel_hi, input logic [3:0] strb);
    return sel_hi ? {strb, 4'b0000} : {4'b0000, strb};
  endfunction

endpackage

// File: rtl/tcm_pmem_axi.sv
// AXI4 slave giving the system bus access to port 1 of the 64-bit TCM RAM.
// One INCR burst at a time; each 32-bit beat becomes a byte-strobed 64-bit
// RAM write or a one-cycle-latency RAM read.
// Optional feature: define TCM_PMEM_RANGE_CHECK_EN to reject beats whose
// address is >= TCM_RAM_SIZE (no RAM write, SLVERR, read data forced to 0).
module tcm_pmem_axi
  import tcm_pkg::*;
#(
  parameter int unsigned TCM_RAM_SIZE = 32'd49152
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       axi_awvalid_i,
  input  logic [31:0]                axi_awaddr_i,
  input  logic [3:0]                 axi_awid_i,
  input  logic [7:0]                 axi_awlen_i,
  output logic                       axi_awready_o,
  input  logic                       axi_wvalid_i,
  input  logic [31:0]                axi_wdata_i,
  input  logic [3:0]                 axi_wstrb_i,
  input  logic                       axi_wlast_i,
  output logic                       axi_wready_o,
  output logic                       axi_bvalid_o,
  output logic [1:0]                 axi_bresp_o,
  output logic [3:0]                 axi_bid_o,
  input  logic                       axi_bready_i,
  input  logic                       axi_arvalid_i,
  input  logic [31:0]                axi_araddr_i,
  input  logic [3:0]                 axi_arid_i,
  input  logic [7:0]                 axi_arlen_i,
  output logic                       axi_arready_o,
  output logic                       axi_rvalid_o,
  output logic [31:0]                axi_rdata_o,
  output logic [1:0]                 axi_rresp_o,
  output logic [3:0]                 axi_rid_o,
  output logic                       axi_rlast_o,
  input  logic                       axi_rready_i,
  output logic [TCM_WORD_ADDR_W-1:0] ram_addr_o,
  output logic [63:0]                ram_data_o,
  output logic [7:0]                 ram_wr_o,
  input  logic [63:0]                ram_data_i
);

`ifdef TCM_PMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  cnt_q;
  logic [3:0]  id_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        live_q;   // low in the first cycle after reset so IDLE readies rise afterwards

  logic aw_hs, ar_hs, w_hs, r_hs;
  logic last_beat;
  logic out_of_range;
  logic unused;

  // WLAST is deliberately ignored: the latched beat count ends the burst.
  assign unused = axi_wlast_i;

  assign aw_hs        = axi_awvalid_i && axi_awready_o;
  assign ar_hs        = axi_arvalid_i && axi_arready_o;
  assign w_hs         = axi_wvalid_i  && axi_wready_o;
  assign r_hs         = axi_rvalid_o  && axi_rready_i;
  assign last_beat    = (cnt_q == len_q);
  assign out_of_range = RANGE_CHECK && (addr_q >= TCM_RAM_SIZE);

  // State register.
  // NOTE: asynchronous active-low reset sits in the sensitivity list; all sequential state uses non-blocking assignment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs; write wins over read when both arrive in IDLE.
  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    axi_awready_o = 1'b0;
    axi_arready_o = 1'b0;
    axi_wready_o  = 1'b0;
    axi_bvalid_o  = 1'b0;
    axi_rvalid_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        axi_awready_o = live_q;
        axi_arready_o = live_q && !axi_awvalid_i;
        if (live_q && axi_awvalid_i)      state_d = ST_WR;
        else if (live_q && axi_arvalid_i) state_d = ST_RD_ADDR;
      end
      ST_WR: begin
        axi_wready_o = 1'b1;
        if (axi_wvalid_i && last_beat) state_d = ST_BRESP;
      end
      ST_BRESP: begin
        axi_bvalid_o = 1'b1;
        if (axi_bready_i) state_d = ST_IDLE;
      end
      ST_RD_ADDR: state_d = ST_RD_CAP;
      ST_RD_CAP:  state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        axi_rvalid_o = 1'b1;
        if (axi_rready_i) state_d = last_beat ? ST_IDLE : ST_RD_ADDR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst bookkeeping: latch on address handshake, advance on each data beat, capture read data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      live_q  <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rresp_q <= AXI_RESP_OKAY;
    end else begin
      live_q <= 1'b1;
      if (aw_hs) begin
        addr_q <= axi_awaddr_i;
        len_q  <= axi_awlen_i;
        id_q   <= axi_awid_i;
        cnt_q  <= '0;
        err_q  <= 1'b0;
      end else if (ar_hs) begin
        addr_q <= axi_araddr_i;
        len_q  <= axi_arlen_i;
        id_q   <= axi_arid_i;
        cnt_q  <= '0;
      end
      if (w_hs) begin
        addr_q <= addr_q + 32'd4;
        cnt_q  <= cnt_q + 8'd1;
        err_q  <= err_q | out_of_range;
      end
      // Captured copy keeps R stable during stalls even if port 0 rewrites the word.
      if (state_q == ST_RD_CAP) begin
        rdata_q <= out_of_range ? 32'd0 : (addr_q[2] ? ram_data_i[63:32] : ram_data_i[31:0]);
        rresp_q <= out_of_range ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
      if (r_hs && !last_beat) begin
        addr_q <= addr_q + 32'd4;
        cnt_q  <= cnt_q + 8'd1;
      end
    end
  end

  assign axi_bresp_o = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign axi_bid_o   = id_q;
  assign axi_rdata_o = rdata_q;
  assign axi_rresp_o = rresp_q;
  assign axi_rid_o   = id_q;
  assign axi_rlast_o = axi_rvalid_o && last_beat;

  assign ram_addr_o  = addr_q[TCM_WORD_ADDR_W+2:3];
  assign ram_data_o  = {axi_wdata_i, axi_wdata_i};
  assign ram_wr_o    = (w_hs && !out_of_range) ? lane_enables(addr_q[2], axi_wstrb_i) : 8'h00;

endmodule
